// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default base
// address (same value as the core's idle data address) and port polarities.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000;

  localparam logic RDATA_EN_ACTIVE   = 1'b1;
  localparam logic WDATA_EN_ACTIVE   = 1'b1;
  localparam logic DATA_READY_ACTIVE = 1'b1;

endpackage

// File: rtl/dmem_sram_array.sv
// Word-organised data storage: combinational read port, byte-masked
// synchronous write port. Contents are intentionally not reset.
module dmem_sram_array #(
  parameter int XLEN        = 64,
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = 12
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_waddr,
  input  logic [XLEN-1:0]    i_wdata,
  input  logic [XLEN/8-1:0]  i_wmask,
  input  logic [IDX_W-1:0]   i_raddr,
  output logic [XLEN-1:0]    o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  assign o_rdata = r_mem[i_raddr];

  // Byte-lane write: only lanes with a set strobe are updated.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (i_wmask[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-port responder with programmable wait states and access faults.
// Optional build macro: DMEM_ALIGN_CHECK_EN (fault accesses not aligned to a word).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int                XLEN        = 64,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic               rdata_en,
  input  logic               wdata_en,
  input  logic [XLEN-1:0]    wdata,
  input  logic [XLEN/8-1:0]  wmask,
  output logic [XLEN-1:0]    rdata,
  output logic               data_ready,
  output logic               access_fault
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

  dmem_state_e r_state;
  dmem_state_e w_next_state;

  logic [3:0]         r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_is_wr;
  logic               r_fault;
  logic [XLEN-1:0]    r_wdata;
  logic [XLEN/8-1:0]  r_wmask;
  logic [XLEN-1:0]    r_rdata;
  logic               r_ready;
  logic               r_access_fault;

  logic               w_req_rd;
  logic               w_req_wr;
  logic               w_req;
  logic [ADDR_W-1:0]  w_offset;
  logic [ADDR_W-1:0]  w_word;
  logic               w_oor;
  logic               w_misalign;
  logic               w_fault_in;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_sel_wr;
  logic               w_sel_fault;
  logic [XLEN-1:0]    w_arr_rdata;
  logic               w_we;
  logic               w_ready_nx;
  logic               w_fault_nx;
  logic [XLEN-1:0]    w_rdata_nx;

  assign w_req_rd = (rdata_en == RDATA_EN_ACTIVE);
  assign w_req_wr = (wdata_en == WDATA_EN_ACTIVE);
  assign w_req    = w_req_rd | w_req_wr;

  // Offset wraps, so addresses below the base land far out of range.
  assign w_offset = data_addr - BASE_ADDR;
  assign w_word   = w_offset >> 3;
  assign w_oor    = (w_word >= ADDR_W'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = (data_addr[2:0] != 3'd0);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault_in = w_oor | w_misalign;

  // With zero wait states RESP follows IDLE directly, before the request is latched.
  assign w_sel_idx   = (r_state == ST_IDLE) ? w_word[IDX_W-1:0] : r_idx;
  assign w_sel_wr    = (r_state == ST_IDLE) ? w_req_wr          : r_is_wr;
  assign w_sel_fault = (r_state == ST_IDLE) ? w_fault_in        : r_fault;

  assign w_we = (r_state == ST_RESP) && r_is_wr && !r_fault;

  dmem_sram_array #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_wmask (r_wmask),
    .i_raddr (w_sel_idx),
    .o_rdata (w_arr_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort takes priority over the final WAIT count.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next_state = (LP_WAIT == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request capture in IDLE and wait-counter maintenance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_is_wr <= 1'b0;
      r_fault <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_cnt   <= LP_WAIT;
            r_idx   <= w_word[IDX_W-1:0];
            r_is_wr <= w_req_wr;
            r_fault <= w_fault_in;
            r_wdata <= wdata;
            r_wmask <= wmask;
          end
        end
        ST_WAIT: begin
          if (w_next_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_cnt <= 4'd0;
          end
        end
        default: r_cnt <= 4'd0;
      endcase
    end
  end

  // Output next values: computed on the edge that enters RESP.
  always_comb begin
    w_ready_nx = (w_next_state == ST_RESP);
    w_fault_nx = w_ready_nx & w_sel_fault;
    w_rdata_nx = r_rdata;
    if (w_ready_nx) begin
      if (w_sel_fault) begin
        w_rdata_nx = '0;
      end else if (!w_sel_wr) begin
        w_rdata_nx = w_arr_rdata;
      end else begin
        w_rdata_nx = r_rdata;
      end
    end else begin
      w_rdata_nx = r_rdata;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready        <= 1'b0;
      r_access_fault <= 1'b0;
      r_rdata        <= '0;
    end else begin
      r_ready        <= w_ready_nx;
      r_access_fault <= w_fault_nx;
      r_rdata        <= w_rdata_nx;
    end
  end

  assign data_ready   = r_ready ? DATA_READY_ACTIVE : ~DATA_READY_ACTIVE;
  assign access_fault = r_access_fault;
  assign rdata        = r_rdata;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the core's MEM-stage data port. It accepts the read/write requests the core issues (address, read enable, write enable, write data), models a word-organised data RAM with a programmable wait-state count, and returns read data plus a one-cycle completion pulse that the pipeline uses to release its MEM-stage stall. The core drives the initiator side of this port; this block sits between that port and the RAM storage.

## Interface
Parameters:
- XLEN, 64, data word width in bits; one word is 8 bytes.
- ADDR_W, 32, data address width.
- DEPTH_WORDS, 4096, number of XLEN words of storage.
- BASE_ADDR, 32'h8000_0000, byte address of word 0. This is the same value the core drives as the idle address.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response, 0..15.

Ports:
- clk, input, 1, sole clock.
- rst_n, input, 1, asynchronous active-low reset.
- data_addr, input, ADDR_W, byte address of the request.
- rdata_en, input, 1, read request, active high.
- wdata_en, input, 1, write request, active high.
- wdata, input, XLEN, write data.
- wmask, input, XLEN/8, byte-lane write strobes; bit i enables byte i.
- rdata, output, XLEN, read data, registered.
- data_ready, output, 1, one-cycle completion pulse.
- access_fault, output, 1, qualifies data_ready; high means the access was rejected.

## Operation
- FSM states:
  - IDLE: A request is accepted when rdata_en or wdata_en is high. The block latches the address, the kind of access, the write data and the write mask, and loads the wait counter with WAIT_CYCLES. It then goes to WAIT, or straight to RESP if WAIT_CYCLES is 0.
  - WAIT: The counter decrements each cycle. When it reaches 1, the next state is RESP. If both rdata_en and wdata_en drop, the request is aborted: the block returns to IDLE with no write and no data_ready pulse. This is the flush/cancel path.
  - RESP: data_ready is high for exactly one cycle. Any write commits in this cycle. The next state is always IDLE.
- A new request is never accepted in RESP. The initiator deasserts or changes its request in the cycle after data_ready.
- If rdata_en and wdata_en are both high, the access is treated as a write.
- Address decode:
  - offset = data_addr - BASE_ADDR, using unsigned ADDR_W arithmetic with wrap.
  - word index = offset >> 3.
  - If the index is DEPTH_WORDS or greater, the access is out of range: access_fault=1, nothing is written, and rdata is loaded with 0.
- Reads: rdata loads the array word in the cycle of the transition into RESP. It holds that value until the next read response.
- Writes: only bytes whose wmask bit is set are updated. rdata does not change on a write.
- Reset values: state IDLE, data_ready 0, access_fault 0, rdata 0, counter 0. Array contents are not reset.
- Reset asserted mid-access: the FSM returns to IDLE immediately. No write commits and no pulse is produced.

## Timing
- Read latency from the acceptance edge to data_ready is WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0 the response comes in the next cycle.
- Back-to-back accesses are spaced at least WAIT_CYCLES+2 cycles apart, because RESP is followed by one IDLE cycle.
- Inputs are sampled only in IDLE. Changes to the address or data during WAIT are ignored, except that dropping both enables aborts the request.
- The abort check in WAIT is made every cycle, including the last WAIT cycle.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: an access with data_addr[2:0] != 0 is faulted with the same behaviour as out-of-range (access_fault=1, no write, rdata=0).
- DMEM_ALIGN_CHECK_EN undefined: data_addr[2:0] is ignored and the access goes to the containing word.

## Structure
- The shared package holds:
  - the FSM state encoding (IDLE/WAIT/RESP);
  - the default DMEM base address (shared with the core's reset/idle address);
  - the enable-polarity constants for rdata_en, wdata_en and data_ready.
- One sub-module, dmem_sram_array:
  - DEPTH_WORDS x XLEN storage;
  - combinational read port;
  - byte-masked synchronous write port.
- The FSM, the decode and the fault logic stay in dmem_responder.

## Test plan
- WAIT_CYCLES=1: write 64'h1122_3344_5566_7788 with full mask to 0x8000_0010, then read the same address. Required: the read's data_ready comes 2 cycles after acceptance with rdata=64'h1122_3344_5566_7788 and access_fault=0.
- Partial write: wmask=8'h0F, wdata=64'hFFFF_FFFF_AAAA_BBBB to the word above, then read. Required: rdata=64'h1122_3344_AAAA_BBBB.
- Out-of-range read of BASE_ADDR+DEPTH_WORDS*8. Required: data_ready with access_fault=1 and rdata=0. Also read 0x7FFF_FFF8, which wraps below the base. Required: faulted.
- WAIT_CYCLES=3: drop both enables in the second WAIT cycle of a write. Required: no data_ready, and a subsequent read returns the old contents.
- rst_n pulsed low during WAIT. Required: data_ready=0, state IDLE, no write. With DMEM_ALIGN_CHECK_EN, a read of 0x8000_0004 faults; without it, the read returns word 0.
